// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - bus-side and UART-side signal bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  in_wr;
    logic [7:0]            in_data;
    logic                  in_full;
    logic                  flush;
    logic [DEPTH_LOG2:0]   level;
    logic                  empty;
    logic                  idle;
    logic                  uart_wr;
    logic [7:0]            uart_data;
    logic                  uart_busy;

    modport slave (
        input  in_wr, in_data, flush, uart_busy,
        output in_full, level, empty, idle, uart_wr, uart_data
    );

    modport master (
        output in_wr, in_data, flush, uart_busy,
        input  in_full, level, empty, idle, uart_wr, uart_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that drains into the UART core one write strobe at a time
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        SETTLE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   level;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            uart_wr_q;
    logic [7:0]      uart_data_q;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == PW'(DEPTH));
    assign empty = (level == '0);

    // in_full is taken from the pre-edge level, so a same-cycle pop never frees room.
    assign push = bus.in_wr && !full && !bus.flush;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !bus.uart_busy && !bus.flush) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:  state_d = SETTLE;
            // Guard cycle: the UART's registered busy is not yet valid here.
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            uart_wr_q   <= 1'b0;
            uart_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            uart_wr_q <= pop;
            if (pop) begin
                uart_data_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (bus.flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_full   = full;
    assign bus.level     = level;
    assign bus.empty     = empty;
    assign bus.idle      = empty && (state_q == IDLE) && !bus.uart_busy;
    assign bus.uart_wr   = uart_wr_q;
    assign bus.uart_data = uart_data_q;
endmodule
